data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single-port data memory (data_mem) between two requesters: port A (pipeline MEM stage) and
//  port B (debug/loader). Per access: arbitrates, drives the memory port for one cycle, waits out the
//  1-cycle registered read, then returns an ack and the read data. Sits between the requesters and data_mem.
// PARAMETERS
//  ADDR_W   11  memory word-address width
//  DATA_W   33  memory data width; matches the data_mem word
// PORTS
//  clock         in   1       single clock; all state updates on posedge
//  reset_n       in   1       synchronous, active-low reset; sampled on posedge clock
//  a_req         in   1       port A request; held with a_addr/a_wdata/a_write stable until a_ack
//  a_write       in   1       1=write, 0=read
//  a_addr        in   ADDR_W  word address
//  a_wdata       in   DATA_W  write data
//  a_ack         out  1       one-cycle completion pulse
//  a_rdata       out  DATA_W  read data; valid from a_ack and held until A's next read completes
//  b_*           --   --      identical set for port B
//  mem_address   out  ADDR_W  to data_mem address
//  mem_in_data   out  DATA_W  to data_mem in_data
//  mem_write     out  1       to data_mem write
//  mem_read      out  1       to data_mem read
//  mem_out_data  in   DATA_W  from data_mem out_data; registered there, valid 1 cycle after the read edge
// BEHAVIOUR
//  - FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. All outputs come from registers or registered state
//    only; no combinational path from any input to any output.
//  - IDLE: if a_req|b_req, pick a winner and latch owner/write/addr/wdata -> ACCESS. Else stay in IDLE.
//  - ACCESS: mem_address/mem_in_data are driven from the latched values. mem_write=write and
//    mem_read=!write. data_mem acts on the edge that ends ACCESS.
//  - WAIT: mem_write=mem_read=0. On a read, mem_out_data is copied into owner's rdata register at the
//    end of WAIT. On a write, rdata is left unchanged.
//  - RESP: owner's ack=1 for exactly one cycle -> IDLE.
//  - Latency: a req seen in IDLE at cycle 0 gets its ack at cycle 3. Maximum throughput is one access per
//    4 cycles.
//  - Requester protocol: drop req in the cycle after ack. A req still high in IDLE counts as a new access.
//  - Changes to a request's inputs are ignored after the request is latched.
//  - Simultaneous a_req & b_req in IDLE: arbitration rule below. The loser keeps waiting; there is no
//    timeout.
//  - mem_write and mem_read are never both 1. At most one ack is high in any cycle.
//  - Address range: addresses cover the full 2^ADDR_W words. There is no out-of-range check.
//  - Reset values: state=IDLE, a_ack=b_ack=0, mem_write=mem_read=0, mem_address=0, mem_in_data=0,
//    a_rdata=b_rdata=0, round-robin pointer=A.
//  - Reset mid-access: the FSM aborts to IDLE and no ack is issued. If reset_n is sampled low on the edge
//    that ends ACCESS, that write still commits, because data_mem samples the registered mem_write.
//    The requester must reissue after reset.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: round-robin arbitration. The 1-bit pointer holds the last owner. On a tie the
//    other port wins. The pointer updates on entry to ACCESS.
//  DMEM_ARB_RR_EN undefined: fixed priority, port A always wins a tie. The pointer is absent and B may starve.
// STRUCTURE
//  - Package dmem_arb_pkg holds: ADDR_W/DATA_W defaults, the FSM state encoding (2-bit: IDLE/ACCESS/WAIT/RESP),
//    and the owner IDs PORT_A=0 and PORT_B=1.
//  - Sub-module dmem_arb_pick: combinational winner select from a_req, b_req, and the pointer. It holds the
//    DMEM_ARB_RR_EN conditional.
//  - data_mem is instantiated by the parent, not by this block.
// TESTING
//  1. Port A only: write 0x1_2345_6789 to addr 5, then read addr 5. Expect mem_write=1 only in the ACCESS cycle,
//     a_ack at cycle 3 of each access, and a_rdata=0x1_2345_6789.
//  2. a_req and b_req raised together, both reading addr 7, which holds 0x0AA. Without the macro: A is
//     served first and B is acked 4 cycles after A. With DMEM_ARB_RR_EN, after a prior A access: B is
//     served first.
//  3. A writes 0x155 to addr 2047 while B reads addr 0 (which holds 0x0). Expect b_rdata=0x0. Expect
//     a_rdata to keep its previous value, since writes do not touch rdata.
//  4. reset_n pulled low during WAIT of a B read. Expect: no b_ack, all outputs at reset values next cycle,
//     and a B request reissued after release completes normally.
//  5. b_req held continuously while a_req toggles every access. Without the macro B starves whenever a_req
//     is high in IDLE. With DMEM_ARB_RR_EN, A and B acks alternate.
//  6. a_addr/a_wdata changed after ACCESS has started. Expect the memory to see the latched values only.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM states, owner IDs.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 11;
  localparam int DMEM_DATA_W = 33;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select for the data-memory arbiter.
// DMEM_ARB_RR_EN defined: round-robin on a tie (port that did not own last wins).
// DMEM_ARB_RR_EN undefined: fixed priority, port A wins a tie; no pointer input.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
  input  logic i_last,
`endif
  input  logic i_a_req,
  input  logic i_b_req,
  output logic o_winner
);

  // Pick the owner of the next access from the current requests.
  always_comb begin
    o_winner = PORT_A;
    if (i_a_req && i_b_req) begin
`ifdef DMEM_ARB_RR_EN
      o_winner = (i_last == PORT_A) ? PORT_B : PORT_A;
`else
      o_winner = PORT_A;
`endif
    end else if (i_b_req) begin
      o_winner = PORT_B;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port data_mem (A = MEM stage, B = debug/loader).
// Each access: IDLE -> ACCESS (drive memory) -> WAIT (registered read) -> RESP (ack) -> IDLE.
// Every output is a register. Build option: DMEM_ARB_RR_EN selects round-robin tie-breaking.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_out_data
);

  arb_state_e        r_state;
  arb_port_e         r_owner;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              r_a_ack;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
`ifdef DMEM_ARB_RR_EN
  arb_port_e         r_last;
`endif

  logic              w_winner;
  logic              w_win_write;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
    .i_last   (r_last),
`endif
    .i_a_req  (a_req),
    .i_b_req  (b_req),
    .o_winner (w_winner)
  );

  assign w_win_write = (w_winner == PORT_B) ? b_write : a_write;
  assign w_win_addr  = (w_winner == PORT_B) ? b_addr  : a_addr;
  assign w_win_wdata = (w_winner == PORT_B) ? b_wdata : a_wdata;

  // Access sequencer: latches the winner's request, drives the memory, captures read data, acks.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= PORT_A;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
`ifdef DMEM_ARB_RR_EN
      r_last      <= PORT_A;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (a_req || b_req) begin
            r_owner     <= arb_port_e'(w_winner);
            r_write     <= w_win_write;
            r_addr      <= w_win_addr;
            r_wdata     <= w_win_wdata;
            r_mem_write <= w_win_write;
            r_mem_read  <= !w_win_write;
`ifdef DMEM_ARB_RR_EN
            r_last      <= arb_port_e'(w_winner);
`endif
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!r_write) begin
            if (r_owner == PORT_A) r_a_rdata <= mem_out_data;
            else                   r_b_rdata <= mem_out_data;
          end
          if (r_owner == PORT_A) r_a_ack <= 1'b1;
          else                   r_b_ack <= 1'b1;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign a_ack       = r_a_ack;
  assign b_ack       = r_b_ack;
  assign a_rdata     = r_a_rdata;
  assign b_rdata     = r_b_rdata;
  assign mem_address = r_addr;
  assign mem_in_data = r_wdata;
  assign mem_write   = r_mem_write;
  assign mem_read    = r_mem_read;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter with a data_mem stand-in and a transaction-level reference model.
module tb_data_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 33;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_req = 1'b0, a_write = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_ack;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_write = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_ack;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in_data;
  logic          mem_write, mem_read;
  logic [DW-1:0] mem_out_data = '0;

  always #5 clock = ~clock;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_in_data(mem_in_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_out_data(mem_out_data)
  );

  // data_mem stand-in: synchronous write, registered read; cleared on the first edge.
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  bit dmem_clr = 1'b1;
  always @(posedge clock) begin
    if (dmem_clr) begin
      for (int unsigned i = 0; i < (1 << AW); i++) dmem[i] <= '0;
      dmem_clr <= 1'b0;
    end else begin
      if (mem_write) dmem[mem_address] <= mem_in_data;
      if (mem_read)  mem_out_data <= dmem[mem_address];
    end
  end

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  int errors = 0;
  int checks = 0;

  // Reference state: memory contents, per-port rdata, outstanding requests, arbiter schedule.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_rd [2];
  bit            act [2];
  txn_t          cur [2];
  txn_t          qa[$], qb[$];
  bit            serving = 1'b0;
  int            own = 0, start_c = 0, idle_at = 0, cyc = 0, last = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive_port(input int p, input bit req, input txn_t t);
    if (p == 0) begin
      a_req = req; a_write = t.wr; a_addr = t.addr; a_wdata = t.data;
    end else begin
      b_req = req; b_write = t.wr; b_addr = t.addr; b_wdata = t.data;
    end
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    t.wr   = bit'($urandom_range(0, 1));
    t.data = r[DW-1:0];
    case ($urandom_range(0, 5))
      0: t.addr = 11'd0;
      1: t.addr = 11'd2;
      2: t.addr = 11'd5;
      3: t.addr = 11'd7;
      4: t.addr = 11'd2047;
      default: t.addr = AW'($urandom_range(0, 2047));
    endcase
    return t;
  endfunction

  function automatic txn_t mk(input bit wr, input int unsigned addr, input logic [DW-1:0] data);
    txn_t t;
    t.wr = wr; t.addr = AW'(addr); t.data = data;
    return t;
  endfunction

  // One clock cycle: check this cycle's outputs against the schedule, then update requests.
  task automatic step(input int pa, input int pb);
    bit   ackc;
    txn_t s;
    ackc = serving && (cyc == start_c + 3);
    chk("a_ack", a_ack, ackc && own == 0);
    chk("b_ack", b_ack, ackc && own == 1);
    chk("rw_excl", mem_write & mem_read, 0);
    if (serving && cyc == start_c + 1) begin
      chk("acc_write", mem_write, cur[own].wr);
      chk("acc_read", mem_read, !cur[own].wr);
      chk("acc_addr", mem_address, cur[own].addr);
      if (cur[own].wr) chk("acc_wdata", mem_in_data, cur[own].data);
      if ($urandom_range(0, 1) == 1) begin
        s = rand_txn();
        s.wr = cur[own].wr;
        drive_port(own, 1'b1, s);
      end
    end
    if (serving && cyc == start_c + 2) begin
      chk("wait_write", mem_write, 0);
      chk("wait_read", mem_read, 0);
    end
    if (ackc) begin
      if (cur[own].wr) ref_mem[cur[own].addr] = cur[own].data;
      else             exp_rd[own] = ref_mem[cur[own].addr];
      chk("a_rdata", a_rdata, exp_rd[0]);
      chk("b_rdata", b_rdata, exp_rd[1]);
      act[own] = 1'b0;
      serving  = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (!act[p]) begin
        if (p == 0 && qa.size() > 0) begin
          cur[p] = qa.pop_front(); act[p] = 1'b1;
        end else if (p == 1 && qb.size() > 0) begin
          cur[p] = qb.pop_front(); act[p] = 1'b1;
        end else if ($urandom_range(0, 99) < ((p == 0) ? pa : pb)) begin
          cur[p] = rand_txn(); act[p] = 1'b1;
        end
        drive_port(p, act[p], cur[p]);
      end
    end
    if (!serving && cyc >= idle_at && (act[0] || act[1])) begin
      if (act[0] && act[1]) begin
`ifdef DMEM_ARB_RR_EN
        own = (last == 0) ? 1 : 0;
`else
        own = 0;
`endif
      end else begin
        own = act[0] ? 0 : 1;
      end
      serving = 1'b1;
      start_c = cyc;
      idle_at = cyc + 4;
      last    = own;
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((act[0] || act[1] || qa.size() > 0 || qb.size() > 0) && n < 300) begin
      step(0, 0);
      n++;
    end
    chk("drain_done", {act[0], act[1], qa.size() > 0, qb.size() > 0}, 0);
  endtask

  initial begin
    int n;
    int pa_tab [5] = '{100, 0, 100, 50, 30};
    int pb_tab [5] = '{0, 100, 100, 100, 30};
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    act[0] = 1'b0; act[1] = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_in_data", mem_in_data, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    reset_n = 1'b1;
    cyc = 0; idle_at = 0; last = 0;

    // Port A write then read-back of addr 5.
    qa.push_back(mk(1'b1, 5, 33'h1_2345_6789));
    qa.push_back(mk(1'b0, 5, '0));
    drain();

    // Seed addr 7 from A, then both ports read it together.
    qa.push_back(mk(1'b1, 7, 33'h0AA));
    drain();
    qa.push_back(mk(1'b0, 7, '0));
    qb.push_back(mk(1'b0, 7, '0));
    drain();

    // A writes the top address while B reads addr 0; A's rdata must not move.
    qa.push_back(mk(1'b1, 2047, 33'h155));
    qb.push_back(mk(1'b0, 0, '0));
    drain();

    // Reset during WAIT of a B read, then let the still-raised request complete.
    qb.push_back(mk(1'b0, 7, '0));
    n = 0;
    while (!(serving && own == 1 && cyc == start_c + 2) && n < 20) begin
      step(0, 0);
      n++;
    end
    chk("reach_wait", n < 20, 1);
    reset_n = 1'b0;
    @(posedge clock); @(negedge clock); cyc++;
    chk("mrst_a_ack", a_ack, 0);
    chk("mrst_b_ack", b_ack, 0);
    chk("mrst_mem_write", mem_write, 0);
    chk("mrst_mem_read", mem_read, 0);
    chk("mrst_mem_address", mem_address, 0);
    chk("mrst_mem_in_data", mem_in_data, 0);
    chk("mrst_a_rdata", a_rdata, 0);
    chk("mrst_b_rdata", b_rdata, 0);
    @(posedge clock); @(negedge clock); cyc++;
    chk("mrst_b_ack2", b_ack, 0);
    serving = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0; last = 0; idle_at = cyc;
    drive_port(1, 1'b1, cur[1]);
    reset_n = 1'b1;
    drain();

    // Random traffic at several request densities, including B held continuously.
    for (int ph = 0; ph < 5; ph++) begin
      for (int k = 0; k < 200; k++) step(pa_tab[ph], pb_tab[ph]);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
